// File: rtl/blob_center_track.sv
// blob_center_track: turns a blob bounding box into clamped, slew-limited,
// rate-limited pan/tilt servo duties.
module blob_center_track #(
    parameter int COORD_W     = 8,
    parameter int DUTY_W      = 8,
    parameter int SHIFT       = 4,
    parameter int OFFSET      = 1,
    parameter int DUTY_MIN    = 0,
    parameter int DUTY_MAX    = 2**DUTY_W-1,
    parameter int RESET_DUTY  = 69,
    parameter int MAX_STEP    = 0,
    parameter int HOLD_CYCLES = 9371648
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic [COORD_W-1:0] iXmin,
    input  logic [COORD_W-1:0] iXmax,
    input  logic [COORD_W-1:0] iYmin,
    input  logic [COORD_W-1:0] iYmax,
    input  logic               iNewCoord,
    output logic               oReady,
    output logic [DUTY_W-1:0]  oXduty,
    output logic [DUTY_W-1:0]  oYduty,
    output logic               oUpdate,
    output logic               oReject
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CENTER = 3'd1;
    localparam logic [2:0] S_SCALE  = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [31:0] LO = 32'(DUTY_MIN);
    localparam logic [31:0] HI = 32'(DUTY_MAX);
    localparam logic signed [DUTY_W+1:0] MS = (DUTY_W+2)'(MAX_STEP);
    localparam logic [DUTY_W-1:0] STEP_D = DUTY_W'(MAX_STEP);

    logic [2:0]         state;
    logic [COORD_W-1:0] xmin, xmax, ymin, ymax, cx, cy;
    logic [DUTY_W-1:0]  tx, ty;
    logic [CNT_W-1:0]   cnt;
    logic               valid;

    assign valid  = iXmin <= iXmax && iYmin <= iYmax;
    assign oReady = state == S_IDLE && !iReset;

    // one extra bit keeps min+max from wrapping
    function automatic logic [COORD_W-1:0] centre(input logic [COORD_W-1:0] a, input logic [COORD_W-1:0] b);
        logic [COORD_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return COORD_W'(s >> 1);
    endfunction

    function automatic logic [DUTY_W-1:0] target(input logic [COORD_W-1:0] c);
        logic [31:0] t;
        t = (32'(c) >> SHIFT) + 32'(OFFSET);
        return DUTY_W'(t < LO ? LO : t > HI ? HI : t);
    endfunction

    function automatic logic [DUTY_W-1:0] slew(input logic [DUTY_W-1:0] cur, input logic [DUTY_W-1:0] tgt);
        logic signed [DUTY_W+1:0] d;
        d = $signed({2'b0, tgt}) - $signed({2'b0, cur});
        return (MAX_STEP == 0 || (d <= MS && d >= -MS)) ? tgt : d > 0 ? cur + STEP_D : cur - STEP_D;
    endfunction

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state   <= S_IDLE;
            xmin    <= '0;
            xmax    <= '0;
            ymin    <= '0;
            ymax    <= '0;
            cx      <= '0;
            cy      <= '0;
            tx      <= '0;
            ty      <= '0;
            cnt     <= '0;
            oXduty  <= DUTY_W'(RESET_DUTY);
            oYduty  <= DUTY_W'(RESET_DUTY);
            oUpdate <= 1'b0;
            oReject <= 1'b0;
        end else begin
            oUpdate <= state == S_STEP;
            oReject <= state == S_IDLE && iNewCoord && !valid;
            case (state)
                S_IDLE: if (iNewCoord && valid) begin
                    xmin  <= iXmin;
                    xmax  <= iXmax;
                    ymin  <= iYmin;
                    ymax  <= iYmax;
                    state <= S_CENTER;
                end
                S_CENTER: begin
                    cx    <= centre(xmin, xmax);
                    cy    <= centre(ymin, ymax);
                    state <= S_SCALE;
                end
                S_SCALE: begin
                    tx    <= target(cx);
                    ty    <= target(cy);
                    state <= S_STEP;
                end
                S_STEP: begin
                    oXduty <= slew(oXduty, tx);
                    oYduty <= slew(oYduty, ty);
                    cnt    <= '0;
                    state  <= S_HOLD;
                end
                S_HOLD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
